// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the SubBytes engine.
package aes_pkg;

  localparam int AES_NB_BYTES = 16;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Byte 0 is the most significant byte of the state (column-major order).
  function automatic byte_t get_byte(input state_t s, input int idx);
    return s[8*(AES_NB_BYTES-1-idx) +: 8];
  endfunction

  // Row r of the state rotates left by r columns.
  function automatic state_t shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(AES_NB_BYTES-1-(row+4*c)) +: 8] = get_byte(s, row + 4*((c+row) % 4));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sbox.sv
// FIPS-197 forward S-box as a purely combinational 256-entry lookup.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] result
);

  localparam byte_t SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign result = SBOX_TABLE[addr];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES forward SubBytes engine, BYTES_PER_CYCLE bytes substituted per cycle.
// Build option: define SUB_BYTES_SHIFTROWS_EN to apply ShiftRows to out_data.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (BYTES_PER_CYCLE < 1 || BYTES_PER_CYCLE > AES_NB_BYTES ||
      (AES_NB_BYTES % BYTES_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("sub_bytes_engine: BYTES_PER_CYCLE=%0d does not divide 16", BYTES_PER_CYCLE);
  end

  // The step wraps to 0 for BYTES_PER_CYCLE=16, matching the 4-bit counter.
  localparam logic [3:0] CNT_STEP = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] CNT_LAST = 4'(AES_NB_BYTES - BYTES_PER_CYCLE);

  fsm_state_t state;
  logic [3:0] cnt;
  state_t     work;
  state_t     work_sub;
  byte_t      sbox_in  [BYTES_PER_CYCLE];
  byte_t      sbox_out [BYTES_PER_CYCLE];

  for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
    assign sbox_in[k] = get_byte(work, int'(cnt) + k);
    sbox u_sbox (
      .addr   (sbox_in[k]),
      .result (sbox_out[k])
    );
  end

  always_comb begin
    // NOTE: work_sub starts as a copy of work before the lane overrides, so no latch is inferred.
    work_sub = work;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      work_sub[8*(AES_NB_BYTES-1-(int'(cnt)+k)) +: 8] = sbox_out[k];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses <= so every flop sees pre-edge values; work is a plain register, so it is reset too.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          work <= work_sub;
          cnt  <= cnt + CNT_STEP;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

`ifdef SUB_BYTES_SHIFTROWS_EN
  assign out_data = shift_rows(work);
`else
  assign out_data = work;
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine: one BPC=1 instance and one BPC=16 instance.
module tb_sub_bytes_engine;

  localparam int LAT_A = 16;
  localparam int LAT_B = 1;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef SUB_BYTES_SHIFTROWS_EN
  localparam logic [127:0] FIPS_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
  localparam logic [127:0] FIPS_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] IN_53    = {8'h53, 120'h0};
  localparam logic [127:0] EXP_53   = {8'hed, {15{8'h63}}};

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_data_a, out_data_a;
  logic         rst_n_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_data_b, out_data_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   seen_a = 0;
  bit   seen_b = 0;
  logic [7:0] sbox_m [256];

  sub_bytes_engine #(.BYTES_PER_CYCLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .busy(busy_a)
  );

  sub_bytes_engine #(.BYTES_PER_CYCLE(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent S-box model: GF(2^8) inverse followed by the affine transform.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] get_b(input logic [127:0] s, input int i);
    return s[8*(15-i) +: 8];
  endfunction

  function automatic logic [127:0] model_block(input logic [127:0] in);
    logic [127:0] sub;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) sub[8*(15-i) +: 8] = sbox_m[get_b(in, i)];
    res = sub;
`ifdef SUB_BYTES_SHIFTROWS_EN
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[8*(15-(r+4*c)) +: 8] = get_b(sub, r + 4*((c+r) % 4));
`endif
    return res;
  endfunction

  // Monitors sample half a cycle after the rising edge, once the driver has settled inputs.
  always begin
    @(negedge clk); #1;
    if (rst_n_a === 1'b1 && out_valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_output: got %h expected none", out_data_a);
      end else begin
        if (!seen_a) begin
          check("a_latency", 128'(cycle - q_a[0].acc), 128'(LAT_A));
          seen_a = 1;
        end
        check("a_data", out_data_a, q_a[0].data);
        if (out_ready_a) begin
          void'(q_a.pop_front());
          seen_a = 0;
        end
      end
    end
  end

  always begin
    @(negedge clk); #1;
    if (rst_n_b === 1'b1 && out_valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_output: got %h expected none", out_data_b);
      end else begin
        if (!seen_b) begin
          check("b_latency", 128'(cycle - q_b[0].acc), 128'(LAT_B));
          seen_b = 1;
        end
        check("b_data", out_data_b, q_b[0].data);
        if (out_ready_b) begin
          void'(q_b.pop_front());
          seen_b = 0;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input bit unit_b, input logic [127:0] data, input logic [127:0] exp,
                      output int acc);
    bit   ok;
    exp_t e;
    ok  = 0;
    acc = -1;
    if (unit_b) begin in_valid_b = 1'b1; in_data_b = data; end
    else        begin in_valid_a = 1'b1; in_data_a = data; end
    for (int n = 0; n < 100 && !ok; n++) begin
      if ((unit_b ? in_ready_b : in_ready_a) === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        ok  = 1;
        acc = cycle;
      end else begin
        @(negedge clk);
      end
    end
    if (unit_b) in_valid_b = 1'b0;
    else        in_valid_a = 1'b0;
    if (ok) begin
      e.data = exp;
      e.acc  = acc;
      if (unit_b) q_b.push_back(e);
      else        q_a.push_back(e);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept_timeout: got no in_ready expected accept", unit_b ? "b" : "a");
    end
  endtask

  task automatic drain(input bit unit_b);
    int n;
    n = 0;
    while ((unit_b ? q_b.size() : q_a.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(unit_b ? "b_drain_empty" : "a_drain_empty",
          128'(unit_b ? q_b.size() : q_a.size()), 128'(0));
  endtask

  initial begin : main
    int acc1, acc2, n;
    logic [127:0] d;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_m[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    rst_n_a = 0; in_valid_a = 0; in_data_a = '0; out_ready_a = 0;
    rst_n_b = 0; in_valid_b = 0; in_data_b = '0; out_ready_b = 0;
    repeat (2) @(negedge clk);

    // Reset state of both instances.
    check("a_rst_in_ready",  in_ready_a,  1'b1);
    check("a_rst_out_valid", out_valid_a, 1'b0);
    check("a_rst_busy",      busy_a,      1'b0);
    check("a_rst_out_data",  out_data_a,  128'h0);
    check("b_rst_in_ready",  in_ready_b,  1'b1);
    check("b_rst_out_valid", out_valid_b, 1'b0);
    check("b_rst_busy",      busy_b,      1'b0);
    rst_n_a = 1; rst_n_b = 1;

    // All-zero block and the FIPS-197 SubBytes vector on the byte-serial instance.
    out_ready_a = 1;
    send(0, 128'h0, ALL_63, acc1);
    drain(0);
    send(0, FIPS_IN, FIPS_EXP, acc1);
    drain(0);

    // Consumer stalls for 10 cycles in DONE while a second block is offered.
    out_ready_a = 0;
    send(0, FIPS_IN, FIPS_EXP, acc1);
    n = 0;
    while (out_valid_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("a_hold_reached_done", out_valid_a, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("a_hold_in_ready", in_ready_a, 1'b0);
      check("a_hold_out_valid", out_valid_a, 1'b1);
      check("a_hold_out_data", out_data_a, FIPS_EXP);
      if (i == 3) begin in_valid_a = 1; in_data_a = {16{8'hff}}; end
      if (i == 7) in_valid_a = 0;
      @(negedge clk);
    end
    out_ready_a = 1;
    @(negedge clk);
    check("a_after_release_valid", out_valid_a, 1'b0);
    check("a_after_release_ready", in_ready_a, 1'b1);
    repeat (3) @(negedge clk);
    check("a_no_stray_output", out_valid_a, 1'b0);
    drain(0);

    // Reset on the fifth BUSY edge aborts the block; a new block is accepted right after.
    send(0, 128'h0123456789abcdeffedcba9876543210, ALL_63, acc1);
    repeat (4) @(negedge clk);
    check("a_busy_before_abort", busy_a, 1'b1);
    rst_n_a = 0;
    @(negedge clk);
    check("a_abort_busy", busy_a, 1'b0);
    check("a_abort_out_valid", out_valid_a, 1'b0);
    check("a_abort_in_ready", in_ready_a, 1'b1);
    check("a_abort_work", out_data_a, 128'h0);
    q_a.delete();
    seen_a = 0;
    rst_n_a = 1;
    send(0, FIPS_IN, FIPS_EXP, acc2);
    check("a_accept_after_reset", 128'(acc2 - acc1), 128'(6));
    drain(0);

    // A few model-checked blocks exercise every byte position of the serial datapath.
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(0, d, model_block(d), acc1);
    end
    drain(0);

    // Full-width instance: back-to-back blocks, one-cycle latency, accepts three cycles apart.
    out_ready_b = 1;
    send(1, IN_53, EXP_53, acc1);
    send(1, 128'h0, ALL_63, acc2);
    check("b_accept_spacing", 128'(acc2 - acc1), 128'(3));
    drain(1);

    // Every byte value through byte 0, with random filler in the other bytes.
    for (int v = 0; v < 256; v++) begin
      d = {8'(v), 24'($urandom), $urandom, $urandom, $urandom};
      send(1, d, model_block(d), acc1);
    end
    drain(1);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
